// File: rtl/posdec_pkg.sv
// Shared types and sizes for the streaming position decoder.
// POSDEC_THERMO_EN selects thermometer decode in posdec_expand.
package posdec_pkg;

  localparam int WIDTH = 16;
  localparam int POS_W = $clog2(WIDTH);
  localparam int CNT_W = POS_W + 1;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/posdec_expand.sv
// Expands a bit position into a mask plus an out-of-range flag.
// POSDEC_THERMO_EN: thermometer mask (bits 0..pos), else one-hot.
module posdec_expand
  import posdec_pkg::*;
(
  input  logic [POS_W-1:0] i_pos,
  output logic [WIDTH-1:0] o_dec,
  output logic             o_oor
);

  assign o_oor = (32'(i_pos) >= 32'(WIDTH));

`ifdef POSDEC_THERMO_EN
  assign o_dec = o_oor ? '0
               : word_t'((32'd2 << i_pos) - 32'd1);
`else
  assign o_dec = o_oor ? '0
               : word_t'(32'd1 << i_pos);
`endif

endmodule

// File: rtl/position_decoder_acc.sv
// Rebuilds a data word from a stream of bit positions, one frame per word.
// POSDEC_THERMO_EN switches to thermometer decode without duplicate checks.
module position_decoder_acc
  import posdec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam cnt_t CNT_MAX = '1;

  state_t r_state;
  state_t w_state_n;

  word_t r_acc;
  cnt_t  r_cnt;
  logic  r_err;
  logic  r_valid;
  word_t r_data;
  cnt_t  r_count;
  logic  r_oerr;

  word_t w_dec;
  logic  w_oor;
  logic  w_dup;
  logic  w_acc_beat;
  word_t w_acc_n;
  cnt_t  w_cnt_n;
  logic  w_err_n;

  posdec_expand u_expand (
    .i_pos (in_pos),
    .o_dec (w_dec),
    .o_oor (w_oor)
  );

  assign in_ready   = (r_state != HOLD);
  assign w_acc_beat = in_valid && in_ready;

`ifdef POSDEC_THERMO_EN
  assign w_dup = 1'b0;
`else
  assign w_dup = |(r_acc & w_dec);
`endif

  assign w_acc_n = r_acc | w_dec;
  assign w_cnt_n = (r_cnt == CNT_MAX) ? r_cnt
                 : r_cnt + cnt_t'(1);
  assign w_err_n = r_err | w_dup | w_oor;

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc_beat)
          w_state_n = in_last ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (w_acc_beat && in_last)
          w_state_n = HOLD;
      end
      HOLD: begin
        if (r_valid && out_ready)
          w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_oerr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_acc_beat) begin
        if (in_last) begin
          r_data  <= w_acc_n;
          r_count <= w_cnt_n;
          r_oerr  <= w_err_n;
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_err   <= 1'b0;
        end else begin
          r_acc <= w_acc_n;
          r_cnt <= w_cnt_n;
          r_err <= w_err_n;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_count = r_count;
  assign out_err   = r_oerr;

endmodule

// File: tb/tb_position_decoder_acc.sv
// Directed bench for position_decoder_acc (one-hot or thermometer build).
// Expected words follow POSDEC_THERMO_EN when the bench is built with it.
module tb_position_decoder_acc;

`ifdef POSDEC_THERMO_EN
  localparam bit THERMO = 1'b1;
`else
  localparam bit THERMO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_pos;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_count;
  logic        out_err;

  int npass;
  int ntot;

  position_decoder_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic beat(input logic [3:0] p, input logic l);
    in_valid = 1'b1;
    in_pos   = p;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string tag,
                            input logic [15:0] d,
                            input logic [4:0]  c,
                            input logic        e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_err"}, 32'(out_err), 32'(e));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    npass     = 0;
    ntot      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    beat(4'd5, 1'b1);
    expect_out("single5", THERMO ? 16'h003F : 16'h0020, 5'd1, 1'b0);

    beat(4'd11, 1'b0);
    beat(4'd1, 1'b1);
    expect_out("pair", THERMO ? 16'h0FFF : 16'h0802, 5'd2, 1'b0);

    for (int i = 0; i < 16; i++)
      beat(4'(i), i == 15);
    expect_out("all16", 16'hFFFF, 5'd16, 1'b0);

    beat(4'd4, 1'b0);
    beat(4'd4, 1'b1);
    expect_out("dup", THERMO ? 16'h001F : 16'h0010, 5'd2, !THERMO);

    beat(4'd0, 1'b1);
    expect_out("after_dup", 16'h0001, 5'd1, 1'b0);

    beat(4'd13, 1'b1);
    in_valid = 1'b1;
    in_pos   = 4'd2;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), THERMO ? 32'h3FFF : 32'h2000);
      chk("bp_inrdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_out("bp_done", THERMO ? 16'h3FFF : 16'h2000, 5'd1, 1'b0);

    beat(4'd9, 1'b1);
    expect_out("post_bp", THERMO ? 16'h03FF : 16'h0200, 5'd1, 1'b0);

    beat(4'd2, 1'b0);
    beat(4'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_inrdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_quiet", 32'(out_valid), 32'd0);
    beat(4'd7, 1'b1);
    expect_out("after_rst", THERMO ? 16'h00FF : 16'h0080, 5'd1, 1'b0);

    beat(4'd6, 1'b1);
    chk("hold_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("holdrst_valid", 32'(out_valid), 32'd0);
    chk("holdrst_inrdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    beat(4'd3, 1'b0);
    beat(4'd7, 1'b1);
    expect_out("f37", THERMO ? 16'h00FF : 16'h0088, 5'd2, 1'b0);

    beat(4'd15, 1'b1);
    expect_out("f15", THERMO ? 16'hFFFF : 16'h8000, 5'd1, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
